// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and memory-wait freeze controller for the 5-stage LEGv8 pipeline.
// Define HAZARD_CTRL_STATS_EN to add the saturating stall_count / flush_count outputs.
module hazard_ctrl #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned ZERO_REG     = 31,
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_rs_used,
  input  logic             if_id_rt_used,
  input  logic             branch_taken,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pipe_hold,
`ifdef HAZARD_CTRL_STATS_EN
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count,
`endif
  output logic             stall_active
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             haz_s;

  // Load in EX writes a register the ID instruction actually reads (XZR excluded).
  always_comb begin
    haz_s = id_ex_memread & (id_ex_rd != REG_W'(ZERO_REG)) &
            ((if_id_rs_used & (id_ex_rd == if_id_rs)) |
             (if_id_rt_used & (id_ex_rd == if_id_rt)));
  end

  // Mealy output decode, highest priority first; reset forces the free-running values.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pipe_hold    = 1'b0;
    stall_active = 1'b0;
    if (reset) begin
      pc_en    = 1'b1;
      if_id_en = 1'b1;
    end else if (mem_wait) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      pipe_hold    = 1'b1;
      stall_active = (state_r == STALL);
    end else if (branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if ((state_r == STALL) || haz_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      stall_active = 1'b1;
    end else begin
      pc_en    = 1'b1;
      if_id_en = 1'b1;
    end
  end

  // Stall sequencer: the detection cycle is the first bubble, cnt counts the remaining ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_W'(0);
    end else if (mem_wait) begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
    end else if (branch_taken) begin
      state_r <= IDLE;
      cnt_r   <= CNT_W'(0);
    end else if (state_r == STALL) begin
      if (cnt_r == CNT_W'(1)) begin
        state_r <= IDLE;
        cnt_r   <= CNT_W'(0);
      end else begin
        state_r <= STALL;
        cnt_r   <= cnt_r - CNT_W'(1);
      end
    end else if (haz_s && (STALL_CYCLES > 1)) begin
      state_r <= STALL;
      cnt_r   <= CNT_W'(STALL_CYCLES - 1);
    end else begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic        flush_acc_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    if (en && (val != 32'hFFFF_FFFF)) begin
      return val + 32'd1;
    end else begin
      return val;
    end
  endfunction

  // A branch only counts when the memory wait is not masking it.
  always_comb begin
    flush_acc_s = branch_taken & ~mem_wait;
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= sat_inc(stall_cnt_r, id_ex_bubble);
      flush_cnt_r <= sat_inc(flush_cnt_r, flush_acc_s);
    end
  end

  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: three instances (STALL_CYCLES 1, 3, 2) share stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       if_id_rs_used;
  logic       if_id_rt_used;
  logic       branch_taken;
  logic       mem_wait;

  // {pc_en, if_id_en, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, pipe_hold, stall_active}
  wire [7:0] o_a;
  wire [7:0] o_b;
  wire [7:0] o_c;
`ifdef HAZARD_CTRL_STATS_EN
  wire [31:0] sc_a, fc_a, sc_b, fc_b, sc_c, fc_c;
`endif

  localparam logic [7:0] N  = 8'b1100_0000;
  localparam logic [7:0] B  = 8'b0010_0001;
  localparam logic [7:0] F  = 8'b1101_1100;
  localparam logic [7:0] WI = 8'b0000_0010;
  localparam logic [7:0] WS = 8'b0000_0011;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rs_used(if_id_rs_used),
    .if_id_rt_used(if_id_rt_used), .branch_taken(branch_taken), .mem_wait(mem_wait),
    .pc_en(o_a[7]), .if_id_en(o_a[6]), .id_ex_bubble(o_a[5]), .flush_if_id(o_a[4]),
    .flush_id_ex(o_a[3]), .flush_ex_mem(o_a[2]), .pipe_hold(o_a[1]),
`ifdef HAZARD_CTRL_STATS_EN
    .stall_count(sc_a), .flush_count(fc_a),
`endif
    .stall_active(o_a[0]));

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rs_used(if_id_rs_used),
    .if_id_rt_used(if_id_rt_used), .branch_taken(branch_taken), .mem_wait(mem_wait),
    .pc_en(o_b[7]), .if_id_en(o_b[6]), .id_ex_bubble(o_b[5]), .flush_if_id(o_b[4]),
    .flush_id_ex(o_b[3]), .flush_ex_mem(o_b[2]), .pipe_hold(o_b[1]),
`ifdef HAZARD_CTRL_STATS_EN
    .stall_count(sc_b), .flush_count(fc_b),
`endif
    .stall_active(o_b[0]));

  hazard_ctrl #(.STALL_CYCLES(2), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rs_used(if_id_rs_used),
    .if_id_rt_used(if_id_rt_used), .branch_taken(branch_taken), .mem_wait(mem_wait),
    .pc_en(o_c[7]), .if_id_en(o_c[6]), .id_ex_bubble(o_c[5]), .flush_if_id(o_c[4]),
    .flush_id_ex(o_c[3]), .flush_ex_mem(o_c[2]), .pipe_hold(o_c[1]),
`ifdef HAZARD_CTRL_STATS_EN
    .stall_count(sc_c), .flush_count(fc_c),
`endif
    .stall_active(o_c[0]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, queue its expectation, compare 1 ns later.
  task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic rsu, input logic rtu,
                      input logic br, input logic mw, input logic rst,
                      input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                      input string tag);
    exp_t e;
    @(negedge clk);
    id_ex_memread = mr;
    id_ex_rd      = rd;
    if_id_rs      = rs;
    if_id_rt      = rt;
    if_id_rs_used = rsu;
    if_id_rt_used = rtu;
    branch_taken  = br;
    mem_wait      = mw;
    reset         = rst;
    e.a = ea;
    e.b = eb;
    e.c = ec;
    exp_q.push_back(e);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_s1"}, {24'd0, o_a}, {24'd0, e.a});
      chk({tag, "_s3"}, {24'd0, o_b}, {24'd0, e.b});
      chk({tag, "_s2"}, {24'd0, o_c}, {24'd0, e.c});
    end
  endtask

  task automatic idle(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                      input string tag);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, ec, tag);
  endtask

  task automatic haz(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                     input string tag);
    step(1'b1, 5'd2, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ea, eb, ec, tag);
  endtask

  initial begin
    // Reset dominates a concurrent hazard and branch.
    step(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, N, N, N, "rst_dom");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, N, N, N, "rst");
    step(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, N, N, N, "no_match");

    // rs hazard: 1, 3 and 2 bubbles respectively.
    haz(B, B, B, "rs_det");
    idle(N, B, B, "rs_b2");
    idle(N, B, N, "rs_b3");
    idle(N, N, N, "rs_end");

    // XZR and unused-operand matches never stall.
    step(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, N, N, N, "xzr");
    step(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, N, N, N, "rt_unused");

    // rt hazard, then rs==rt==rd gives a single sequence.
    step(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, B, B, B, "rt_det");
    idle(N, B, B, "rt_b2");
    idle(N, B, N, "rt_b3");
    step(1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, B, B, B, "same_det");
    idle(N, B, B, "same_b2");
    idle(N, B, N, "same_b3");
    idle(N, N, N, "same_end");

    // Memory wait during the second bubble freezes the sequence.
    haz(B, B, B, "mw_det");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, WI, WS, WS, "mw_hold1");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, WI, WS, WS, "mw_hold2");
    idle(N, B, B, "mw_b2");
    idle(N, B, N, "mw_b3");
    idle(N, N, N, "mw_end");

    // Branch masked by memory wait, then accepted.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, WI, WI, WI, "br_masked");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, F, F, F, "br_accept");

    // Hazard and branch together: flush wins, no bubble.
    step(1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, F, F, F, "haz_br");
    idle(N, N, N, "haz_br_next");

    // Branch during STALL aborts the sequence.
    haz(B, B, B, "brs_det");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, F, F, F, "brs_flush");
    idle(N, N, N, "brs_end");

    // Reset during STALL aborts immediately.
    haz(B, B, B, "rsts_det");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, N, N, N, "rsts_rst");
    idle(N, N, N, "rsts_end");

    // Back-to-back dependent loads; hazard inside STALL is not re-evaluated.
    haz(B, B, B, "b2b_1");
    haz(B, B, B, "b2b_2");
    idle(N, B, N, "b2b_3");
    idle(N, N, N, "b2b_end");

`ifdef HAZARD_CTRL_STATS_EN
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, N, N, N, "st_rst");
    haz(B, B, B, "st_h1");
    idle(N, B, B, "st_i1");
    haz(B, B, B, "st_h2");
    idle(N, N, B, "st_i2");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, F, F, F, "st_br");
    idle(N, N, N, "st_end");
    chk("stall_count_s2", sc_c, 32'd4);
    chk("flush_count_s2", fc_c, 32'd1);
    chk("stall_count_s1", sc_a, 32'd2);
    chk("stall_count_s3", sc_b, 32'd3);
    chk("flush_count_s3", fc_b, 32'd1);
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
